// File: rtl/sram_pkg.sv
// Shared encodings for the wait-state SRAM responder and its storage array.
package sram_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic op_t;
  localparam op_t OP_RD = 1'b0;
  localparam op_t OP_WR = 1'b1;

  function automatic logic [CNT_W-1:0] wait_cnt(input int w);
    return w[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port 32-bit word storage: synchronous write, registered synchronous read.
module sram_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Wait-state data-memory responder with sramRdy completion and optional sramErr
// request checking (enabled by defining SRAM_RESP_ERR_EN).
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sramA,
  inout  wire  [31:0] sramData,
  input  logic        sramWe,
  input  logic        sramRe,
  output logic        sramRdy,
  output logic        sramErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_t              op_q, op_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata;
  logic             req;
  logic             bad_req;
  logic             access;

  assign req = sramRe | sramWe;

`ifdef SRAM_RESP_ERR_EN
  assign bad_req = (sramRe & sramWe) | (sramA[1:0] != 2'b00) | (sramA[31:AW+2] != '0);
`else
  // Unchecked build: byte offset and upper bits are dropped so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{sramA[31:AW+2], sramA[1:0]};
  assign bad_req     = 1'b0;
`endif

  assign access = (state_q == S_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            // sramWe wins when both are high (only reachable in the unchecked build)
            op_d    = sramWe ? OP_WR : OP_RD;
            addr_d  = sramA[AW+1:2];
            wdata_d = sramWe ? sramData : wdata_q;
            cnt_d   = sramWe ? wait_cnt(WRITE_WAIT) : wait_cnt(READ_WAIT);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we_i   (access && (op_q == OP_WR)),
    .re_i   (access && (op_q == OP_RD)),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );

  assign sramData = ((state_q == S_DONE) && (op_q == OP_RD) && sramRe) ? rdata : {32{1'bz}};
  assign sramRdy  = rdy_q;
  assign sramErr  = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: instance A uses READ_WAIT=2/WRITE_WAIT=1,
// instance B uses zero wait states. Pull-ups make an undriven bus read all ones.
module tb_sram_responder;

  localparam logic [31:0] HIZ = 32'hFFFF_FFFF;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_v [2];
  logic [31:0] wd_v   [2];
  logic        we_v   [2];
  logic        re_v   [2];
  logic        den_v  [2];
  logic        rdy_v  [2];
  logic        err_v  [2];
  wire  [31:0] bus_a;
  wire  [31:0] bus_b;

  int          checks   = 0;
  int          failures = 0;
  bit          err_seen = 1'b0;
  logic [31:0] mdl [2][1024];
  exp_t        sb_q [$];

  always #5 clk = ~clk;

  assign bus_a = den_v[0] ? wd_v[0] : {32{1'bz}};
  assign bus_b = den_v[1] ? wd_v[1] : {32{1'bz}};
  pullup (bus_a);
  pullup (bus_b);

  sram_responder #(.DEPTH_WORDS(1024), .READ_WAIT(2), .WRITE_WAIT(1)) u_dut_a (
    .clk(clk), .rst(rst), .sramA(addr_v[0]), .sramData(bus_a), .sramWe(we_v[0]),
    .sramRe(re_v[0]), .sramRdy(rdy_v[0]), .sramErr(err_v[0]));

  sram_responder #(.DEPTH_WORDS(1024), .READ_WAIT(0), .WRITE_WAIT(0)) u_dut_b (
    .clk(clk), .rst(rst), .sramA(addr_v[1]), .sramData(bus_b), .sramWe(we_v[1]),
    .sramRe(re_v[1]), .sramRdy(rdy_v[1]), .sramErr(err_v[1]));

  always @(negedge clk) if (err_v[0] === 1'b1 || err_v[1] === 1'b1) err_seen = 1'b1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] bus_of(input int s);
    return (s == 0) ? bus_a : bus_b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input bit we, input bit re, input logic [31:0] a,
                       input logic [31:0] d);
    addr_v[s] = a;
    we_v[s]   = we;
    re_v[s]   = re;
    wd_v[s]   = d;
    den_v[s]  = we;
  endtask

  task automatic access(input int s, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, input int lat, input bit drop, input string tag);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #1;
    drive(s, we, re, a, d);
    e.rd   = re && !we;
    e.lat  = lat;
    e.data = (e.rd && !drop) ? mdl[s][a[11:2]] : HIZ;
    if (we) mdl[s][a[11:2]] = d;
    sb_q.push_back(e);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 32) begin
      @(posedge clk); #1;
      n++;
      if (drop) re_v[s] = 1'b0;
      @(negedge clk);
      if (rdy_v[s] === 1'b1) seen = 1'b1;
    end
    e = sb_q.pop_front();
    chk({tag, "_rdy"}, 32'(rdy_v[s]), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    chk({tag, "_err"}, 32'(err_v[s]), 32'd0);
    if (e.rd) chk({tag, "_data"}, bus_of(s), e.data);
    @(posedge clk); #1;
    drive(s, 1'b0, 1'b0, a, 32'd0);
    @(negedge clk);
    chk({tag, "_after_rdy"}, 32'(rdy_v[s]), 32'd0);
    chk({tag, "_after_bus"}, bus_of(s), HIZ);
  endtask

  task automatic bad_req(input bit we, input bit re, input logic [31:0] a, input string tag);
    @(posedge clk); #1;
    drive(0, we, re, a, 32'hBAD0_0BAD);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, a, 32'd0);
    @(negedge clk);
    chk({tag, "_err"}, 32'(err_v[0]), 32'd1);
    chk({tag, "_rdy"}, 32'(rdy_v[0]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_quiet"}, {30'd0, rdy_v[0], err_v[0]}, 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    bit   exp_rdy;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy_a", 32'(rdy_v[0]), 32'd0);
    chk("rst_err_a", 32'(err_v[0]), 32'd0);
    chk("rst_bus_a", bus_a, HIZ);
    chk("rst_rdy_b", 32'(rdy_v[1]), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Establish known contents, then abort a write with reset mid-BUSY
    access(0, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 3, 1'b0, "pre_wr10");
    access(0, 1'b1, 1'b0, 32'h00, 32'h00C0_FFEE, 3, 1'b0, "pre_wr00");
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    @(posedge clk); #2;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    chk("abort_rdy", 32'(rdy_v[0]), 32'd0);
    chk("abort_err", 32'(err_v[0]), 32'd0);
    chk("abort_bus", bus_a, HIZ);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_hold", {30'd0, rdy_v[0], err_v[0]}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    access(0, 1'b0, 1'b1, 32'h10, 32'd0, 4, 1'b0, "abort_rd10");

    // Write then read with latency W+2
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 3, 1'b0, "wr10");
    access(0, 1'b0, 1'b1, 32'h10, 32'd0, 4, 1'b0, "rd10");

    // Read request dropped during BUSY still completes without driving the bus
    access(0, 1'b0, 1'b1, 32'h10, 32'd0, 4, 1'b1, "drop_rd10");

`ifdef SRAM_RESP_ERR_EN
    bad_req(1'b0, 1'b1, 32'h0000_0012, "err_misalign");
    bad_req(1'b1, 1'b1, 32'h0000_0000, "err_both");
    bad_req(1'b0, 1'b1, 32'h0001_0000, "err_range");
    access(0, 1'b0, 1'b1, 32'h10, 32'd0, 4, 1'b0, "err_chk10");
    access(0, 1'b0, 1'b1, 32'h00, 32'd0, 4, 1'b0, "err_chk00");
`else
    access(0, 1'b1, 1'b0, 32'h1000, 32'h0000_0001, 3, 1'b0, "wrap_wr");
    access(0, 1'b0, 1'b1, 32'h0000, 32'd0, 4, 1'b0, "wrap_rd");
    access(0, 1'b1, 1'b1, 32'h0008, 32'h0BAD_CAFE, 3, 1'b0, "both_wr");
    access(0, 1'b0, 1'b1, 32'h0008, 32'd0, 4, 1'b0, "both_rd");
    chk("no_err_seen", 32'(err_seen), 32'd0);
`endif

    // Zero-wait instance: back-to-back reads with the request held high
    access(1, 1'b1, 1'b0, 32'h0, 32'hA5A5_0000, 2, 1'b0, "b_wr0");
    access(1, 1'b1, 1'b0, 32'h4, 32'h5A5A_0004, 2, 1'b0, "b_wr4");
    sb_q.push_back('{1'b1, mdl[1][0], 2});
    sb_q.push_back('{1'b1, mdl[1][1], 5});
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b1, 32'h0, 32'd0);
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 3) addr_v[1] = 32'h4;
        if (c == 6) re_v[1] = 1'b0;
      end
      @(negedge clk);
      exp_rdy = (c == 2 || c == 5);
      chk($sformatf("b2b_rdy_c%0d", c), 32'(rdy_v[1]), 32'(exp_rdy));
      if (exp_rdy) begin
        e = sb_q.pop_front();
        chk($sformatf("b2b_cycle_c%0d", c), 32'(c), 32'(e.lat));
        chk($sformatf("b2b_data_c%0d", c), bus_b, e.data);
      end else begin
        chk($sformatf("b2b_bus_c%0d", c), bus_b, HIZ);
      end
    end
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
